// File: rtl/rv32_branch_pkg.sv
// Shared definitions for the RV32I execute-stage branch resolver.
//   - funct3 encodings of the conditional branches
//   - resolver FSM state type
package rv32_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_REDIRECT,
    BR_FLUSH
  } br_state_e;

endpackage

// File: rtl/Compa32bitSign.sv
// Signed magnitude comparator.
//   a, b : operands (two's complement)
//   lt   : a < b (signed)
//   eq   : a == b
module Compa32bitSign #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = $signed(a) < $signed(b);
  assign eq = (a == b);

endmodule

// File: rtl/Compa32bitUnsign.sv
// Unsigned magnitude comparator.
//   a, b : operands
//   lt   : a < b (unsigned)
module Compa32bitUnsign #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic             lt
);

  assign lt = (a < b);

endmodule

// File: rtl/branch_cond.sv
// Branch condition evaluator: combines the signed/unsigned comparator results
// according to funct3.
//   rs1, rs2 : register operands
//   funct3   : branch condition code
//   cond     : 1 when the branch condition holds (010/011 never hold)
module branch_cond
  import rv32_branch_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] rs1,
  input  logic [Width-1:0] rs2,
  input  logic [2:0]       funct3,
  output logic             cond
);

  logic lt_s;
  logic lt_u;
  logic eq;

  Compa32bitSign #(
    .Width(Width)
  ) u_cmp_s (
    .a (rs1),
    .b (rs2),
    .lt(lt_s),
    .eq(eq)
  );

  Compa32bitUnsign #(
    .Width(Width)
  ) u_cmp_u (
    .a (rs1),
    .b (rs2),
    .lt(lt_u)
  );

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = ~eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = ~lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolver. Evaluates conditional branches, JAL and
// JALR, computes the target, issues a ready/valid redirect to fetch and then
// holds o_flush for FLUSH_CYCLES cycles.
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_valid / o_ready     : instruction handshake (o_ready only in IDLE)
//   i_is_branch/jal/jalr  : instruction class (priority jalr > jal > branch)
//   i_funct3              : branch condition
//   i_pc, i_rs1, i_rs2    : PC and register operands
//   i_imm                 : sign-extended immediate
//   o_taken, o_misalign   : one-cycle result pulses (mutually exclusive)
//   o_link_pc             : pc+4 of the last accepted instruction
//   o_redirect_valid/pc   : redirect request to fetch, i_redirect_ready accepts
//   o_flush               : squash younger stages
// All outputs are registered.
module branch_resolve
  import rv32_branch_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_is_branch,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_taken,
  output logic [XLEN-1:0] o_link_pc,
  output logic            o_misalign,
  output logic            o_redirect_valid,
  input  logic            i_redirect_ready,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush
);

  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES);

  br_state_e       state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            ready_q, ready_d;
  logic            taken_q, taken_d;
  logic            misalign_q, misalign_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] link_pc_q, link_pc_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  // Decode and target computation
  logic            cond;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            taken_raw;
  logic            accept;
  logic            go_taken;
  logic            go_misalign;
  logic            handshake;

  branch_cond #(
    .Width(XLEN)
  ) u_cond (
    .rs1   (i_rs1),
    .rs2   (i_rs2),
    .funct3(i_funct3),
    .cond  (cond)
  );

  assign pc_target = i_pc + i_imm;
  assign jalr_sum  = i_rs1 + i_imm;
  assign target    = i_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_target;
  assign taken_raw = i_is_jalr | i_is_jal | (i_is_branch & cond);

  // ready_q is only ever set while state_q is IDLE, so it gates acceptance.
  assign accept      = i_valid & ready_q;
  assign go_taken    = accept & taken_raw & ~target[1];
  assign go_misalign = accept & taken_raw & target[1];
  assign handshake   = redirect_valid_q & i_redirect_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= BR_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BR_IDLE: begin
        if (go_taken) state_d = BR_REDIRECT;
      end
      BR_REDIRECT: begin
        if (handshake) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = BR_IDLE;
          end else begin
            state_d = BR_FLUSH;
            cnt_d   = FlushInit;
          end
        end
      end
      BR_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        // Flush is high while cnt counts FLUSH_CYCLES..1
        if (cnt_q <= 4'd1) state_d = BR_IDLE;
      end
      default: state_d = BR_IDLE;
    endcase
  end

  // Output next-values, decoded from the upcoming state so outputs are registered
  always_comb begin
    ready_d          = (state_d == BR_IDLE);
    redirect_valid_d = (state_d == BR_REDIRECT);
    flush_d          = (state_d == BR_FLUSH);
    taken_d          = go_taken;
    misalign_d       = go_misalign;
    link_pc_d        = accept ? (i_pc + XLEN'(4)) : link_pc_q;
    redirect_pc_d    = go_taken ? target : redirect_pc_q;
  end

  // Output registers; reset clears everything including o_ready
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ready_q          <= 1'b0;
      taken_q          <= 1'b0;
      misalign_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      link_pc_q        <= '0;
      redirect_pc_q    <= '0;
    end else begin
      ready_q          <= ready_d;
      taken_q          <= taken_d;
      misalign_q       <= misalign_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      link_pc_q        <= link_pc_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign o_ready          = ready_q;
  assign o_taken          = taken_q;
  assign o_misalign       = misalign_q;
  assign o_redirect_valid = redirect_valid_q;
  assign o_flush          = flush_q;
  assign o_link_pc        = link_pc_q;
  assign o_redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: a table of single-instruction
// vectors plus hand-written sequences for stall, busy-ignore, reset-in-flush
// and a zero-flush build.
module tb_branch_resolve;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        valid0;
  logic        is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [31:0] pc, rs1, rs2, imm;
  logic        rdy_in;

  logic        ready, taken, misalign, rvalid, flush;
  logic [31:0] link_pc, rpc;
  logic        ready0, taken0, misalign0, rvalid0, flush0;
  logic [31:0] link_pc0, rpc0;

  int n_cmp;
  int n_fail;

  branch_resolve #(
    .XLEN        (32),
    .FLUSH_CYCLES(2)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (valid),
    .o_ready         (ready),
    .i_is_branch     (is_branch),
    .i_is_jal        (is_jal),
    .i_is_jalr       (is_jalr),
    .i_funct3        (funct3),
    .i_pc            (pc),
    .i_rs1           (rs1),
    .i_rs2           (rs2),
    .i_imm           (imm),
    .o_taken         (taken),
    .o_link_pc       (link_pc),
    .o_misalign      (misalign),
    .o_redirect_valid(rvalid),
    .i_redirect_ready(rdy_in),
    .o_redirect_pc   (rpc),
    .o_flush         (flush)
  );

  branch_resolve #(
    .XLEN        (32),
    .FLUSH_CYCLES(0)
  ) dut0 (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (valid0),
    .o_ready         (ready0),
    .i_is_branch     (is_branch),
    .i_is_jal        (is_jal),
    .i_is_jalr       (is_jalr),
    .i_funct3        (funct3),
    .i_pc            (pc),
    .i_rs1           (rs1),
    .i_rs2           (rs2),
    .i_imm           (imm),
    .o_taken         (taken0),
    .o_link_pc       (link_pc0),
    .o_misalign      (misalign0),
    .o_redirect_valid(rvalid0),
    .i_redirect_ready(1'b1),
    .o_redirect_pc   (rpc0),
    .o_flush         (flush0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        br;
    logic        jal;
    logic        jalr;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        exp_taken;
    logic        exp_mis;
    logic [31:0] exp_link;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic set_instr(input logic b, input logic j, input logic jr, input logic [2:0] f,
                           input logic [31:0] p, input logic [31:0] a, input logic [31:0] c,
                           input logic [31:0] im);
    is_branch = b;
    is_jal    = j;
    is_jalr   = jr;
    funct3    = f;
    pc        = p;
    rs1       = a;
    rs2       = c;
    imm       = im;
  endtask

  task automatic wait_ready(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!ready && n < max_cycles) begin
      step();
      n++;
    end
    check1({name, " ready within bound"}, ready, 1'b1);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    valid  = 1'b0;
    valid0 = 1'b0;
    rdy_in = 1'b0;
    set_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);

    //                br    jal   jalr  f3      pc            rs1           rs2           imm
    //                taken mis   link          target
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b100, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0001,
                 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0120};       // BLT
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b110, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0001,
                 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0104, 32'h0};               // BLTU
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0200, 32'h0000_1001, 32'h0,
                 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0204, 32'h0000_1004};       // JALR
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0300, 32'h0, 32'h0,
                 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0304, 32'h0};               // JAL misalign
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0400, 32'h5, 32'h5,
                 32'hFFFF_FFF0, 1'b1, 1'b0, 32'h0000_0404, 32'h0000_03F0};       // BEQ backward
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'b001, 32'h0000_0400, 32'h5, 32'h5,
                 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0404, 32'h0};               // BNE equal
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'b101, 32'h0000_0500, 32'h1, 32'hFFFF_FFFF,
                 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0504, 32'h0000_0508};       // BGE
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'b111, 32'h0000_0500, 32'h1, 32'hFFFF_FFFF,
                 32'h0000_0008, 1'b0, 1'b0, 32'h0000_0504, 32'h0};               // BGEU
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0580, 32'h9, 32'h9,
                 32'h0000_0008, 1'b0, 1'b0, 32'h0000_0584, 32'h0};               // f3=010
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFF_FFF0, 32'h0, 32'h0,
                 32'h0000_0020, 1'b1, 1'b0, 32'hFFFF_FFF4, 32'h0000_0010};       // JAL wrap
    vecs[10] = '{1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0A00, 32'h1, 32'h2,
                 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0A04, 32'h0};               // non-control
    vecs[11] = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0600, 32'h8, 32'h8,
                 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0604, 32'h0000_0018};       // jalr wins
    vecs[12] = '{1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0700, 32'h0000_2003, 32'h0,
                 32'h0, 1'b0, 1'b1, 32'h0000_0704, 32'h0};                       // JALR misalign

    // Reset state
    step();
    step();
    check1("reset ready", ready, 1'b0);
    check1("reset taken", taken, 1'b0);
    check1("reset misalign", misalign, 1'b0);
    check1("reset rvalid", rvalid, 1'b0);
    check1("reset flush", flush, 1'b0);
    check32("reset link_pc", link_pc, 32'h0);
    check32("reset redirect_pc", rpc, 32'h0);
    rst_n = 1'b1;
    step();
    check1("post-reset ready", ready, 1'b1);

    // Table vectors, fetch always ready
    rdy_in = 1'b1;
    for (int i = 0; i < 13; i++) begin
      wait_ready($sformatf("v%0d pre", i), 10);
      set_instr(vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].f3, vecs[i].pc, vecs[i].rs1,
                vecs[i].rs2, vecs[i].imm);
      valid = 1'b1;
      step();
      valid = 1'b0;
      check1($sformatf("v%0d taken", i), taken, vecs[i].exp_taken);
      check1($sformatf("v%0d misalign", i), misalign, vecs[i].exp_mis);
      check32($sformatf("v%0d link_pc", i), link_pc, vecs[i].exp_link);
      check1($sformatf("v%0d rvalid", i), rvalid, vecs[i].exp_taken);
      if (vecs[i].exp_taken) check32($sformatf("v%0d redirect_pc", i), rpc, vecs[i].exp_tgt);
      else check1($sformatf("v%0d ready stays", i), ready, 1'b1);
      step();
      check1($sformatf("v%0d taken pulse ends", i), taken, 1'b0);
      check1($sformatf("v%0d misalign pulse ends", i), misalign, 1'b0);
      wait_ready($sformatf("v%0d post", i), 10);
    end

    // Stalled redirect, with a second taken branch held on i_valid throughout
    rdy_in = 1'b0;
    set_instr(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0800, 32'h7, 32'h7, 32'h0000_0100);
    valid = 1'b1;
    step();
    check1("stall taken", taken, 1'b1);
    check1("stall rvalid c1", rvalid, 1'b1);
    check32("stall rpc c1", rpc, 32'h0000_0900);
    check32("stall link", link_pc, 32'h0000_0804);
    set_instr(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0700, 32'h3, 32'h3, 32'h0000_0040);
    for (int k = 2; k <= 3; k++) begin
      step();
      check1($sformatf("stall rvalid c%0d", k), rvalid, 1'b1);
      check32($sformatf("stall rpc c%0d", k), rpc, 32'h0000_0900);
      check1($sformatf("stall taken c%0d", k), taken, 1'b0);
      check1($sformatf("stall ready c%0d", k), ready, 1'b0);
      check1($sformatf("stall flush c%0d", k), flush, 1'b0);
      check32($sformatf("stall link c%0d", k), link_pc, 32'h0000_0804);
    end
    rdy_in = 1'b1;
    step();
    check1("hs rvalid drops", rvalid, 1'b0);
    check1("hs flush 1", flush, 1'b1);
    check1("hs ready 0", ready, 1'b0);
    check32("hs link ignored", link_pc, 32'h0000_0804);
    step();
    check1("flush 2", flush, 1'b1);
    check1("flush 2 ready", ready, 1'b0);
    step();
    check1("flush ends", flush, 1'b0);
    check1("idle ready", ready, 1'b1);
    check1("idle no taken", taken, 1'b0);
    step();
    valid = 1'b0;
    check1("second taken", taken, 1'b1);
    check32("second rpc", rpc, 32'h0000_0740);
    check32("second link", link_pc, 32'h0000_0704);
    check1("second rvalid", rvalid, 1'b1);
    wait_ready("second", 10);

    // Reset during the first flush cycle
    set_instr(1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0040, 32'h0, 32'h0, 32'h0000_0040);
    valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    check1("pre-reset flush", flush, 1'b1);
    rst_n = 1'b0;
    step();
    check1("rst ready", ready, 1'b0);
    check1("rst taken", taken, 1'b0);
    check1("rst misalign", misalign, 1'b0);
    check1("rst rvalid", rvalid, 1'b0);
    check1("rst flush", flush, 1'b0);
    check32("rst link", link_pc, 32'h0);
    check32("rst rpc", rpc, 32'h0);
    rst_n = 1'b1;
    step();
    check1("rst release ready", ready, 1'b1);
    check1("rst release flush", flush, 1'b0);

    // Zero-flush build: back-to-back taken jumps with fetch always ready
    check1("z ready initial", ready0, 1'b1);
    set_instr(1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0040, 32'h0, 32'h0, 32'h0000_0040);
    valid0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check1($sformatf("z rvalid c%0d", k), rvalid0, (k % 2) == 0);
      check1($sformatf("z taken c%0d", k), taken0, (k % 2) == 0);
      check1($sformatf("z ready c%0d", k), ready0, (k % 2) != 0);
      check1($sformatf("z flush c%0d", k), flush0, 1'b0);
      if (k == 0) check32("z rpc", rpc0, 32'h0000_0080);
    end
    valid0 = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
